// File: rtl/serial_pattern_transmitter.sv
// Serial "1011" pattern source: MSB-first frame shifter with optional idle gap
// and a tracker that counts detector matches per frame.
module serial_pattern_transmitter #(
  parameter int WIDTH      = 16,
  parameter int GAP_CYCLES = 2,
  parameter int LW         = $clog2(WIDTH+1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LW-1:0]    load_len,
  output logic             sequence_out,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_done,
  output logic [LW-1:0]    match_count
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES+1) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  typedef enum logic [2:0] {T0, T1, T10, T101, T1011} trk_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  trk_t             trk_q, trk_d, trk_nx;
  logic [LW-1:0]    mcnt_q, mcnt_d, mcnt_adv;
  logic [LW-1:0]    match_q, match_d;
  logic             done_q, done_d;
  logic             last_bit, accept, cur_bit;
  logic [LW-1:0]    len_eff;

  // Frame is held left-aligned so the next bit is always sr_q[WIDTH-1].
  assign cur_bit    = sr_q[WIDTH-1];
  assign last_bit   = (state_q == SEND) && (cnt_q == LW'(1));
  assign load_ready = (state_q == IDLE) || (last_bit && (GAP_CYCLES == 0)) ||
                      ((state_q == GAP) && (gap_q == GW'(1)));
  assign accept     = load_valid && load_ready;
  assign len_eff    = ((load_len == '0) || (load_len > LW'(WIDTH))) ? LW'(WIDTH) : load_len;

  assign out_valid    = (state_q == SEND);
  assign sequence_out = cur_bit & out_valid;
  assign busy         = (state_q != IDLE);
  assign frame_done   = done_q;
  assign match_count  = match_q;

  always_comb begin
    trk_nx = trk_q;
    unique case (trk_q)
      T0:      trk_nx = cur_bit ? T1    : T0;
      T1:      trk_nx = cur_bit ? T1    : T10;
      T10:     trk_nx = cur_bit ? T101  : T0;
      T101:    trk_nx = cur_bit ? T1011 : T10;
      T1011:   trk_nx = cur_bit ? T1    : T10;
      default: trk_nx = T0;
    endcase
  end

  // T1011 has no self-loop, so landing there is always a fresh match.
  assign mcnt_adv = mcnt_q + LW'(trk_nx == T1011);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    trk_d   = trk_q;
    mcnt_d  = mcnt_q;
    match_d = match_q;
    done_d  = last_bit;
    if (out_valid) begin
      sr_d   = sr_q << 1;
      cnt_d  = cnt_q - LW'(1);
      trk_d  = trk_nx;
      mcnt_d = mcnt_adv;
    end
    if (last_bit) match_d = mcnt_adv;
    unique case (state_q)
      IDLE: ;
      SEND: begin
        gap_d = GW'(GAP_CYCLES);
        if (last_bit) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new frame overrides the end-of-frame path and restarts the tracker.
    if (accept) begin
      state_d = SEND;
      sr_d    = load_data << (LW'(WIDTH) - len_eff);
      cnt_d   = len_eff;
      trk_d   = T0;
      mcnt_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      trk_q   <= T0;
      mcnt_q  <= '0;
      match_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      trk_q   <= trk_d;
      mcnt_q  <= mcnt_d;
      match_q <= match_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_pattern_transmitter.sv
// Scoreboard bench: DUT 0 is WIDTH=8/GAP=2, DUT 1 is WIDTH=16/GAP=0.
module tb_serial_pattern_transmitter;

  typedef struct {
    logic b;
    bit   last;
    int   gap;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic       lv_a = 1'b0, lv_b = 1'b0;
  logic [7:0] ld_a = '0;
  logic [15:0] ld_b = '0;
  logic [3:0] ln_a = '0;
  logic [4:0] ln_b = '0;
  logic       rdy_a, so_a, ov_a, busy_a, fd_a;
  logic       rdy_b, so_b, ov_b, busy_b, fd_b;
  logic [3:0] mc_a;
  logic [4:0] mc_b;

  serial_pattern_transmitter #(.WIDTH(8), .GAP_CYCLES(2)) u_a (
    .clock(clock), .reset_n(reset_n), .load_valid(lv_a), .load_ready(rdy_a),
    .load_data(ld_a), .load_len(ln_a), .sequence_out(so_a), .out_valid(ov_a),
    .busy(busy_a), .frame_done(fd_a), .match_count(mc_a));

  serial_pattern_transmitter #(.WIDTH(16), .GAP_CYCLES(0)) u_b (
    .clock(clock), .reset_n(reset_n), .load_valid(lv_b), .load_ready(rdy_b),
    .load_data(ld_b), .load_len(ln_b), .sequence_out(so_b), .out_valid(ov_b),
    .busy(busy_b), .frame_done(fd_b), .match_count(mc_b));

  logic       rdy_w[2], so_w[2], ov_w[2], busy_w[2], fd_w[2];
  logic [4:0] mc_w[2];
  assign rdy_w[0] = rdy_a;  assign rdy_w[1] = rdy_b;
  assign so_w[0]  = so_a;   assign so_w[1]  = so_b;
  assign ov_w[0]  = ov_a;   assign ov_w[1]  = ov_b;
  assign busy_w[0] = busy_a; assign busy_w[1] = busy_b;
  assign fd_w[0]  = fd_a;   assign fd_w[1]  = fd_b;
  assign mc_w[0]  = {1'b0, mc_a};
  assign mc_w[1]  = mc_b;

  exp_t bq[2][$];
  int   mq[2][$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  int   last_cyc[2] = '{0, 0};
  bit   pend_fd[2] = '{0, 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Overlapping sliding-window count of 1011 over the frame's bits.
  function automatic int count1011(input logic [15:0] d, input int len);
    int c = 0;
    for (int i = len - 1; i >= 3; i--)
      if ({d[i], d[i-1], d[i-2], d[i-3]} == 4'b1011) c++;
    return c;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (fd_w[k] || pend_fd[k]) begin
        chk("frame_done", 32'(fd_w[k]), 32'(pend_fd[k]));
        if (fd_w[k]) begin
          if (mq[k].size() != 0) chk("match_count", 32'(mc_w[k]), 32'(mq[k].pop_front()));
          else chk("match_unexpected", 32'(fd_w[k]), 0);
        end
      end
      pend_fd[k] = 1'b0;
      if (ov_w[k]) begin
        if (bq[k].size() == 0) chk("bit_unexpected", 32'(ov_w[k]), 0);
        else begin
          e = bq[k].pop_front();
          chk("bit", 32'(so_w[k]), 32'(e.b));
          if (e.gap >= 0) chk("spacing", 32'(cyc - last_cyc[k] - 1), 32'(e.gap));
          last_cyc[k] = cyc;
          pend_fd[k]  = e.last;
        end
      end
    end
  end

  task automatic offer(input int k, input logic [15:0] d, input int len, input bit b2b);
    int w  = (k == 0) ? 8 : 16;
    int g  = (k == 0) ? 2 : 0;
    int le = (len == 0 || len > w) ? w : len;
    int n  = 0;
    exp_t e;
    if (k == 0) begin lv_a = 1'b1; ld_a = d[7:0]; ln_a = 4'(len); end
    else        begin lv_b = 1'b1; ld_b = d;      ln_b = 5'(len); end
    while (!rdy_w[k] && n < 200) begin @(negedge clock); n++; end
    if (n >= 200) begin chk("offer_timeout", 32'(n), 0); return; end
    for (int i = le - 1; i >= 0; i--) begin
      e.b = d[i]; e.last = (i == 0); e.gap = (i == le - 1 && b2b) ? g : -1;
      bq[k].push_back(e);
    end
    mq[k].push_back(count1011(d, le));
    @(posedge clock); #1;
  endtask

  task automatic drop(input int k);
    if (k == 0) lv_a = 1'b0; else lv_b = 1'b0;
  endtask

  task automatic drain(input int k);
    int n = 0;
    do begin @(negedge clock); n++; end
    while ((bq[k].size() != 0 || busy_w[k]) && n < 200);
    @(negedge clock);
    if (n >= 200) chk("drain_timeout", 32'(n), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_valid", 32'(ov_w[k]), 0);
      chk("rst_busy", 32'(busy_w[k]), 0);
      chk("rst_frame_done", 32'(fd_w[k]), 0);
      chk("rst_match", 32'(mc_w[k]), 0);
    end
    reset_n = 1'b1;
    #1;
    chk("rst_ready_a", 32'(rdy_a), 1);
    chk("rst_ready_b", 32'(rdy_b), 1);

    // 0xBB on the gapped DUT, then handshake stall and gap spacing
    offer(0, 16'h00BB, 8, 0);
    drop(0);
    drain(0);
    offer(0, 16'h00BB, 8, 0);
    chk("ready_mid_send", 32'(rdy_a), 0);
    chk("busy_mid_send", 32'(busy_a), 1);
    offer(0, 16'h006D, 8, 1);
    drop(0);
    drain(0);
    offer(0, 16'h0016, 5, 0);
    drop(0);
    drain(0);

    // gapless back-to-back, length 0 and oversize length
    offer(1, 16'h000B, 4, 0);
    offer(1, 16'h0009, 4, 1);
    drop(1);
    drain(1);
    offer(1, 16'hB0B0, 0, 0);
    drop(1);
    drain(1);
    offer(1, 16'h2DDB, 20, 0);
    drop(1);
    drain(1);
    for (int i = 0; i < 6; i++) offer(1, 16'($urandom), $urandom_range(4, 16), i != 0);
    drop(1);
    drain(1);

    // asynchronous reset in the middle of a frame
    offer(0, 16'h00BB, 8, 0);
    drop(0);
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(ov_a), 0);
    chk("arst_seq", 32'(so_a), 0);
    chk("arst_busy", 32'(busy_a), 0);
    chk("arst_match", 32'(mc_a), 0);
    bq[0].delete();
    mq[0].delete();
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("arst_ready", 32'(rdy_a), 1);
    offer(0, 16'h000B, 4, 0);
    drop(0);
    drain(0);

    for (int k = 0; k < 2; k++) begin
      chk("bits_left", 32'(bq[k].size()), 0);
      chk("matches_left", 32'(mq[k].size()), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_pattern_transmitter.md
# serial_pattern_transmitter

Serial bit-stream source that is the transmit end of the team's "1011" sequence-detection path. It accepts a parallel frame of up to WIDTH bits through a valid/ready handshake and shifts it out MSB-first, one bit per clock, onto the single-bit line that feeds the Moore "1011" detector. It optionally inserts idle gap bits after each frame. An internal tracker mirrors the detector's transitions and reports how many "1011" matches each frame contains, so benches and system logic can cross-check the detector.

## Interface
- WIDTH, 16: maximum frame length in bits (≥4).
- GAP_CYCLES, 2: number of idle bit-times (line held 0) inserted after every frame; 0 allowed.
- LW, $clog2(WIDTH+1): width of load_len (derived; do not override).
- clock  in  1  single clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  frame offer.
- load_ready  out  1  frame acceptance possible this cycle.
- load_data  in  WIDTH  frame bits; bit [len-1] is sent first, bit [0] last.
- load_len  in  LW  frame length; 0 or >WIDTH is treated as WIDTH.
- sequence_out  out  1  serial bit to the detector.
- out_valid  out  1  sequence_out carries a frame bit this cycle.
- busy  out  1  state ≠ IDLE.
- frame_done  out  1  one-cycle pulse after a frame's last bit.
- match_count  out  LW  number of "1011" matches in the last completed frame.

## Operation
- The FSM has three states: IDLE, SEND and GAP.
- Accept rule: a frame is accepted on any rising edge where load_valid && load_ready. load_data and load_len are captured into a shift register and a bit counter.
- load_ready = (IDLE) || (SEND && last bit && GAP_CYCLES==0) || (GAP && last gap cycle). This allows gapless back-to-back frames.
- IDLE: sequence_out=0, out_valid=0. Accept moves the FSM to SEND.
- SEND: out_valid=1 and sequence_out = current MSB of the active length. The register shifts and the counter decrements each cycle. After the last bit:
  - accept pending → SEND with the new frame;
  - else GAP_CYCLES>0 → GAP;
  - else → IDLE.
- GAP: sequence_out=0, out_valid=0 for exactly GAP_CYCLES cycles. Then:
  - accept pending → SEND;
  - else → IDLE.
- Tracker: a 5-state Moore machine (T0, T1, T10, T101, T1011) that advances only on cycles with out_valid=1.
  - T0: 1→T1, 0→T0.
  - T1: 1→T1, 0→T10.
  - T10: 1→T101, 0→T0.
  - T101: 1→T1011, 0→T10.
  - T1011: 1→T1, 0→T10.
  - Every entry into T1011 increments the per-frame counter. The counter never wraps, because the maximum count (≤ WIDTH/3) fits in LW bits.
  - Tracker and counter reset to T0/0 on each frame accept, so matches never span frames.
- match_count is updated with the frame's final count in the cycle frame_done is asserted. It holds until the next frame_done.
- Reset (any time, including mid-frame or mid-gap) forces:
  - state IDLE, tracker T0;
  - sequence_out=0, out_valid=0, busy=0, frame_done=0, match_count=0;
  - load_ready=1 after deassertion;
  - the partial frame is discarded.
- load_data and load_len are ignored when no handshake occurs. They may change freely during SEND.

## Timing
- Latency: the first bit appears on sequence_out in the cycle immediately after the accept edge.
- A frame of length L occupies exactly L consecutive out_valid cycles.
- frame_done pulses for one cycle, in the cycle after the last frame bit (first GAP cycle, first bit of the next frame, or first IDLE cycle).
- Frame-to-frame spacing, last bit to next first bit, assuming load_valid is held:
  - GAP_CYCLES=0: 0 cycles;
  - otherwise: exactly GAP_CYCLES idle cycles.
- All outputs are registered; no combinational path from any input to any output except load_ready, which depends only on state.

## Test plan
- Reset, then WIDTH=8, GAP=2: load 0xBB, len 8 → sequence_out 1,0,1,1,1,0,1,1 on 8 consecutive out_valid cycles; 2 zero cycles; frame_done the cycle after the last bit; match_count=2.
- len=4, data=0b1011, GAP=0, load_valid held with second frame 0b1001 → the two frames are emitted contiguously (1,0,1,1,1,0,0,1) with no idle cycle. match_count=1, then 0, because the tracker resets at frame 2 accept.
- load_len=0 with WIDTH=16, data=0xB0B0 → 16 bits emitted MSB-first; match_count=2.
- Handshake: assert load_valid during SEND (non-final bit) → no accept and load_ready=0. The offer is accepted only when load_ready rises.
- Drop reset_n on bit 3 of a frame → outputs are 0 immediately (asynchronously), match_count=0. After release, load_ready=1 and a fresh frame of 0b1011 yields match_count=1.
- Frame 0b10111011 with GAP=1 followed by a frame starting 011 → each frame's match_count counts only its own bits (2, then per frame content). The gap bit never advances the tracker.
